spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flops in each input synchronizer (sclk, mosi, cs); legal values 2..3.
REQ-002 clock_in  input  1  system clock; all state updates on its rising edge.
REQ-003 rs  input  1  reset, synchronous and active-high.
REQ-004 sclk  input  1  SPI serial clock from the master; asynchronous to clock_in.
REQ-005 mosi  input  1  serial data from the master.
REQ-006 cs  input  1  chip select from the master, active-low.
REQ-007 miso  output  1  serial data to the master.
REQ-008 tx_data  input  8  byte to transmit in the next frame.
REQ-009 tx_load  input  1  single-cycle strobe; writes tx_data into the transmit buffer.
REQ-010 tx_ready  output  1  high when the transmit buffer is empty.
REQ-011 rx_data  output  8  last complete received byte; held until the next complete byte.
REQ-012 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-013 tx_underrun  output  1  one-cycle pulse when a byte starts with an empty transmit buffer.
REQ-014 busy  output  1  high while the synchronized cs is low.

Function
REQ-015 Protocol SHALL be SPI mode 0 (idle sclk low): mosi sampled on rising sclk, miso updated on falling sclk; 8-bit bytes, MSB first.
REQ-016 sclk, mosi and cs SHALL each pass through SYNC_STAGES flops; edges SHALL be detected by comparing the last synchronized stage with one further flop.
REQ-017 Legal operation SHALL require each sclk high and low phase to last at least SYNC_STAGES+2 clock_in cycles; behaviour outside this limit is undefined.
REQ-018 FSM states SHALL be IDLE and ACTIVE; IDLE->ACTIVE on synchronized cs falling edge; ACTIVE->IDLE on synchronized cs rising edge.
REQ-019 Byte start (IDLE->ACTIVE entry, or the end of the 8th bit while cs stays low) SHALL load the shift register from the transmit buffer if it is full and mark the buffer empty; otherwise it SHALL load 0x00 and pulse tx_underrun.
REQ-020 At byte start miso SHALL present shift-register bit 7 on the cycle after the load.
REQ-021 In ACTIVE, each synchronized sclk rising edge SHALL shift the synchronized mosi into rx bit 0 and increment a 3-bit bit counter.
REQ-022 In ACTIVE, each synchronized sclk falling edge, except the one after the 8th rising edge, SHALL shift the tx register left and drive the new bit 7 onto miso.
REQ-023 On the 8th rising edge (bit counter wrapping 7->0), rx_data SHALL take the assembled byte and rx_valid SHALL pulse on the following clock_in cycle.
REQ-024 On the falling edge that follows the 8th rising edge, with cs still low, a byte start (REQ-019) SHALL occur, so back-to-back bytes are supported without deasserting cs.
REQ-025 A cs rising edge mid-byte SHALL abort the byte: discard the partial rx bits, reset the bit counter to 0, keep rx_data unchanged, no rx_valid pulse, and keep the transmit buffer contents if it was not consumed.
REQ-026 miso SHALL be driven 1 whenever the FSM is in IDLE.
REQ-027 tx_ready SHALL equal NOT buffer_full; tx_load while the buffer is full SHALL be ignored.
REQ-028 tx_load on the same cycle as a byte start SHALL NOT be used by that byte; that byte uses the buffer state before the load, and the loaded value is held for the next byte.
REQ-029 sclk edges seen while in IDLE SHALL be ignored.

Reset
REQ-030 While rs=1 at a clock_in edge: FSM=IDLE, bit counter=0, shift registers=0x00, rx_data=0x00, rx_valid=0, tx_underrun=0, buffer empty (tx_ready=1), miso=1, busy=0, and all synchronizer flops at the idle levels (sclk 0, mosi 1, cs 1).
REQ-031 A reset asserted mid-frame SHALL take effect immediately; after reset is released the block SHALL wait for a new cs falling edge and treat any sclk activity before it as in IDLE.

Verification
REQ-032 Load 0xA9, then cs low, master sends 0x5C -> miso bits 1,0,1,0,1,0,0,1; rx_data=0x5C; rx_valid is exactly one pulse; tx_ready=1 after the byte start.
REQ-033 No tx_load, one-byte frame -> tx_underrun pulses once at frame start; miso is all 0; rx_data updates normally.
REQ-034 cs held low for two bytes 0x12, 0x34, with 0xF0 loaded during the first byte -> two rx_valid pulses (0x12, then 0x34); second miso byte is 0xF0.
REQ-035 cs raised after 5 sclk rising edges -> no rx_valid; rx_data keeps its previous value; the next full frame receives correctly.
REQ-036 tx_load while tx_ready=0 -> ignored; the original buffer value is transmitted.
REQ-037 rs pulsed mid-byte -> all outputs at their REQ-030 values on the next cycle; the following frame behaves as in REQ-032.

Source files
------------

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode 0 byte slave with synchronized inputs and a one-byte transmit buffer
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clock_in,
    input  logic       i_rs,
    input  logic       i_sclk,
    input  logic       i_mosi,
    input  logic       i_cs,
    output logic       o_miso,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_load,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_tx_underrun,
    output logic       o_busy
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_sr;
    logic [7:0] r_tx_sr;
    logic [7:0] r_buf;
    logic       r_buf_full;
    logic       r_byte_done;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_underrun;

    logic w_sclk;
    logic w_mosi;
    logic w_cs;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_frame_start;
    logic w_abort;
    logic w_active_ok;
    logic w_sample;
    logic w_fall;
    logic w_byte_start;
    logic w_shift;

    // Synchronizers reset to the bus idle levels so reset never fabricates an edge.
    always_ff @(posedge i_clock_in) begin
        if (i_rs) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '1;
            r_cs_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;

    always_ff @(posedge i_clock_in) begin
        if (i_rs) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_cs_fall) w_state_next = ST_ACTIVE;
            ST_ACTIVE: if (w_cs_rise) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // A cs rise wins over any sclk edge decoded in the same cycle.
    assign w_frame_start = (r_state == ST_IDLE) && w_cs_fall;
    assign w_abort       = (r_state == ST_ACTIVE) && w_cs_rise;
    assign w_active_ok   = (r_state == ST_ACTIVE) && !w_cs_rise;
    assign w_sample      = w_active_ok && w_sclk_rise;
    assign w_fall        = w_active_ok && w_sclk_fall;
    assign w_byte_start  = w_frame_start || (w_fall && r_byte_done);
    assign w_shift       = w_fall && !r_byte_done;

    always_ff @(posedge i_clock_in) begin
        if (i_rs) begin
            r_bit_cnt     <= 3'd0;
            r_rx_sr       <= 8'h00;
            r_tx_sr       <= 8'h00;
            r_buf         <= 8'h00;
            r_buf_full    <= 1'b0;
            r_byte_done   <= 1'b0;
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;

            if (w_byte_start) begin
                if (r_buf_full) begin
                    r_tx_sr <= r_buf;
                end else begin
                    r_tx_sr       <= 8'h00;
                    r_tx_underrun <= 1'b1;
                end
            end else if (w_shift) begin
                r_tx_sr <= {r_tx_sr[6:0], 1'b0};
            end

            // A load coinciding with a byte start only lands if the buffer was empty.
            if (w_byte_start && r_buf_full) begin
                r_buf_full <= 1'b0;
            end else if (i_tx_load && !r_buf_full) begin
                r_buf      <= i_tx_data;
                r_buf_full <= 1'b1;
            end

            if (w_abort || w_frame_start) begin
                r_bit_cnt   <= 3'd0;
                r_rx_sr     <= 8'h00;
                r_byte_done <= 1'b0;
            end else if (w_sample) begin
                r_rx_sr   <= {r_rx_sr[6:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_rx_data   <= {r_rx_sr[6:0], w_mosi};
                    r_rx_valid  <= 1'b1;
                    r_byte_done <= 1'b1;
                end
            end else if (w_byte_start) begin
                r_byte_done <= 1'b0;
            end
        end
    end

    assign o_miso        = (r_state == ST_IDLE) ? 1'b1 : r_tx_sr[7];
    assign o_tx_ready    = ~r_buf_full;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_underrun = r_tx_underrun;
    assign o_busy        = ~w_cs;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - randomized SPI master driving spi_slave against a byte-level reference model
module tb_spi_slave;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rs = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b1;
    logic       cs = 1'b1;
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;

    bit         m_full = 1'b0;
    logic [7:0] m_buf = 8'h00;
    logic [7:0] m_rx = 8'h00;
    int         exp_un = 0;

    logic [7:0] rx_q[$];
    int         un_cnt = 0;

    logic [7:0] f_mo[3];
    bit         f_ld[3];
    logic [7:0] f_lv[3];

    spi_slave #(.SYNC_STAGES(2)) dut (
        .i_clock_in   (clk),
        .i_rs         (rs),
        .i_sclk       (sclk),
        .i_mosi       (mosi),
        .i_cs         (cs),
        .o_miso       (miso),
        .i_tx_data    (tx_data),
        .i_tx_load    (tx_load),
        .o_tx_ready   (tx_ready),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .o_tx_underrun(tx_underrun),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_underrun) un_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model of a byte start: the buffered byte is sent if present, otherwise zeros.
    function automatic logic [7:0] model_byte_start();
        logic [7:0] v;
        if (m_full) begin
            v = m_buf;
            m_full = 1'b0;
        end else begin
            v = 8'h00;
            exp_un++;
        end
        return v;
    endfunction

    task automatic load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        wait_cyc(1);
        tx_load = 1'b0;
        if (!m_full) begin
            m_full = 1'b1;
            m_buf  = v;
        end
        check("tx_ready_after_load", tx_ready, !m_full);
    endtask

    task automatic xfer(input logic [7:0] mo, input bit last, input bit do_ld,
                        input logic [7:0] lv, output logic [7:0] mi);
        for (int i = 0; i < 8; i++) begin
            mosi = mo[7-i];
            wait_cyc(H);
            sclk = 1'b1;
            mi[7-i] = miso;
            if (i == 3 && do_ld) begin
                load(lv);
                wait_cyc(H - 1);
            end else begin
                wait_cyc(H);
            end
            sclk = 1'b0;
            if (i == 7 && last) cs = 1'b1;
        end
    endtask

    task automatic frame(input int nb);
        logic [7:0] exp_mi;
        logic [7:0] mi;
        rx_q.delete();
        cs = 1'b0;
        wait_cyc(2 * H);
        check("busy_in_frame", busy, 1'b1);
        for (int b = 0; b < nb; b++) begin
            exp_mi = model_byte_start();
            if (b == 0) check("tx_ready_after_start", tx_ready, !m_full);
            xfer(f_mo[b], b == nb - 1, f_ld[b], f_lv[b], mi);
            check("miso_byte", mi, exp_mi);
        end
        wait_cyc(2 * H);
        check("rx_valid_count", rx_q.size(), nb);
        for (int b = 0; b < nb; b++) begin
            if (rx_q.size() > 0) check("rx_byte", rx_q.pop_front(), f_mo[b]);
        end
        m_rx = f_mo[nb-1];
        check("rx_data_hold", rx_data, m_rx);
        check("underrun_count", un_cnt, exp_un);
        check("tx_ready_idle", tx_ready, !m_full);
        check("busy_idle", busy, 1'b0);
        check("miso_idle", miso, 1'b1);
    endtask

    task automatic abort_frame(input int nbits);
        logic [7:0] junk;
        rx_q.delete();
        cs = 1'b0;
        wait_cyc(2 * H);
        junk = model_byte_start();
        for (int i = 0; i < nbits; i++) begin
            mosi = 1'($urandom);
            wait_cyc(H);
            sclk = 1'b1;
            wait_cyc(H);
            if (i < nbits - 1) sclk = 1'b0;
        end
        sclk = 1'b0;
        cs   = 1'b1;
        wait_cyc(2 * H);
        check("abort_no_rx_valid", rx_q.size(), 0);
        check("abort_rx_data_kept", rx_data, m_rx);
        check("abort_underrun_count", un_cnt, exp_un);
        check("abort_tx_ready", tx_ready, !m_full);
    endtask

    task automatic set_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        f_mo[0] = a; f_mo[1] = b; f_mo[2] = c;
        for (int i = 0; i < 3; i++) begin
            f_ld[i] = 1'b0;
            f_lv[i] = 8'h00;
        end
    endtask

    initial begin
        logic [7:0] junk;
        wait_cyc(3);
        check("rst_miso", miso, 1'b1);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_underrun", tx_underrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rs = 1'b0;
        wait_cyc(4);

        load(8'hA9);
        set_frame(8'h5C, 8'h00, 8'h00);
        frame(1);

        set_frame(8'h96, 8'h00, 8'h00);
        frame(1);

        set_frame(8'h12, 8'h34, 8'h00);
        f_ld[0] = 1'b1;
        f_lv[0] = 8'hF0;
        frame(2);

        load(8'h77);
        abort_frame(5);
        set_frame(8'hC3, 8'h00, 8'h00);
        frame(1);

        load(8'h3C);
        load(8'hC3);
        set_frame(8'h81, 8'h00, 8'h00);
        frame(1);

        load(8'h55);
        cs = 1'b0;
        wait_cyc(2 * H);
        junk = model_byte_start();
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b0;
            wait_cyc(H);
            sclk = 1'b1;
            wait_cyc(H);
            sclk = 1'b0;
        end
        load(8'hEE);
        rs   = 1'b1;
        sclk = 1'b0;
        cs   = 1'b1;
        mosi = 1'b1;
        wait_cyc(1);
        check("midrst_miso", miso, 1'b1);
        check("midrst_tx_ready", tx_ready, 1'b1);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_rx_valid", rx_valid, 1'b0);
        check("midrst_underrun", tx_underrun, 1'b0);
        check("midrst_busy", busy, 1'b0);
        rs = 1'b0;
        m_full = 1'b0;
        m_rx = 8'h00;
        wait_cyc(4);
        load(8'hA9);
        set_frame(8'h5C, 8'h00, 8'h00);
        frame(1);

        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(1, 0) == 1) load(8'($urandom));
            if ($urandom_range(4, 0) == 0) begin
                abort_frame($urandom_range(7, 1));
            end else begin
                set_frame(8'($urandom), 8'($urandom), 8'($urandom));
                for (int i = 0; i < 3; i++) begin
                    f_ld[i] = 1'($urandom);
                    f_lv[i] = 8'($urandom);
                end
                frame($urandom_range(3, 1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
